// File: rtl/chien_search_engine_pkg.sv
// Shared RS(544,514) GF(2^10) definitions: field width, code defaults and
// elaboration-time power-of-alpha helper used to build constant multipliers.
package rs_pkg;
  localparam int M     = 10;
  localparam int N_DEF = 544;
  localparam int T_DEF = 15;
  localparam int P_DEF = 32;
  localparam int Q     = (1 << M) - 1;
  localparam logic [M:0] PRIM_POLY = 11'h409;

  typedef logic [M-1:0] gf_t;

  function automatic gf_t gf_mul_alpha(gf_t a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY[M-1:0] : '0);
  endfunction

  function automatic gf_t gf_mul(gf_t a, gf_t b);
    gf_t acc = '0;
    gf_t x = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc ^= x;
      x = gf_mul_alpha(x);
    end
    return acc;
  endfunction

  // Square-and-multiply keeps elaboration loops short; e may be negative.
  function automatic gf_t gf_alpha_pow(int e);
    int  ex = ((e % Q) + Q) % Q;
    gf_t sq = gf_t'(2);
    gf_t acc = gf_t'(1);
    for (int i = 0; i < M; i++) begin
      if (ex[i]) acc = gf_mul(acc, sq);
      sq = gf_mul(sq, sq);
    end
    return acc;
  endfunction
endpackage

// File: rtl/chien_search_engine_if.sv
// Polynomial handshake and per-beat root outputs of the Chien search engine.
// lam_odd_o is present only when CHIEN_ODD_SUM_EN is defined.
interface chien_search_engine_if import rs_pkg::*; #(
  parameter int N = N_DEF,
  parameter int P = P_DEF,
  parameter int T = T_DEF
) ();
  localparam int PBW = $clog2(N);

  logic                 sigma_start_i;
  logic                 sigma_valid_i;
  logic [(T+1)*M-1:0]   sigma_i;
  logic                 sigma_ready_o;
  logic                 chien_busy;
  logic                 chien_done;
  logic [P-1:0]         hit_mask_o;
  logic [PBW-1:0]       pos_base_o;
`ifdef CHIEN_ODD_SUM_EN
  logic [P*M-1:0]       lam_odd_o;
`endif

  modport master (
    output sigma_start_i, sigma_valid_i, sigma_i,
`ifdef CHIEN_ODD_SUM_EN
    input  lam_odd_o,
`endif
    input  sigma_ready_o, chien_busy, chien_done, hit_mask_o, pos_base_o
  );

  modport slave (
    input  sigma_start_i, sigma_valid_i, sigma_i,
`ifdef CHIEN_ODD_SUM_EN
    output lam_odd_o,
`endif
    output sigma_ready_o, chien_busy, chien_done, hit_mask_o, pos_base_o
  );
endinterface

// File: rtl/gf_const_mul.sv
// Multiply a GF(2^10) element by the fixed constant alpha^E (pure XOR network).
module gf_const_mul import rs_pkg::*; #(
  parameter int E = 0
) (
  input  gf_t a,
  output gf_t y
);
  gf_t terms [M];

  // Column i of the constant matrix is alpha^(E+i).
  for (genvar i = 0; i < M; i++) begin : g_col
    localparam gf_t COL = gf_alpha_pow(E + i);
    assign terms[i] = a[i] ? COL : '0;
  end

  always_comb begin
    y = '0;
    for (int i = 0; i < M; i++) y ^= terms[i];
  end
endmodule

// File: rtl/chien_search_engine.sv
// Parallel Chien search: P positions of Lambda(alpha^-i) per beat, registered outputs.
// Optional CHIEN_ODD_SUM_EN adds per-lane odd-term sums on lam_odd_o.
//   state | meaning
//   IDLE  | ready for a new polynomial
//   SCAN  | evaluating one beat of P positions per cycle
//   DRAIN | last beat leaving the output register
module chien_search_engine import rs_pkg::*; #(
  parameter int N = N_DEF,
  parameter int P = P_DEF,
  parameter int T = T_DEF
) (
  input logic clk_i,
  input logic rst_i,
  chien_search_engine_if.slave bus
);
  localparam int C   = (N + P - 1) / P;
  localparam int CW  = (C > 1) ? $clog2(C) : 1;
  localparam int PBW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  beats_left_q;
  logic [PBW-1:0] pos_q;
  gf_t            r_q [T+1];
  gf_t            r_d [T+1];
  gf_t            lane_term [P][T+1];
  gf_t            lane_sum [P];
  logic [P-1:0]   lane_ok;
  logic           accept, last_beat, scanning;
  logic           busy_q, done_q;
  logic [P-1:0]   hit_q;
  logic [PBW-1:0] base_q;

  assign scanning  = (state_q == SCAN);
  assign accept    = bus.sigma_start_i && bus.sigma_valid_i && (state_q == IDLE);
  assign last_beat = (beats_left_q == '0);

  for (genvar j = 0; j <= T; j++) begin : g_coef
    gf_const_mul #(.E(-j * P)) u_upd (.a(r_q[j]), .y(r_d[j]));
    for (genvar k = 0; k < P; k++) begin : g_lane
      gf_const_mul #(.E(-j * k)) u_term (.a(r_q[j]), .y(lane_term[k][j]));
    end
  end

  always_comb begin
    for (int k = 0; k < P; k++) begin
      lane_sum[k] = '0;
      for (int j = 0; j <= T; j++) lane_sum[k] ^= lane_term[k][j];
      lane_ok[k] = (int'(pos_q) + k) < N;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (last_beat) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      pos_q        <= '0;
      for (int j = 0; j <= T; j++) r_q[j] <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hit_q        <= '0;
      base_q       <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= scanning;
      done_q  <= scanning && last_beat;
      base_q  <= scanning ? pos_q : '0;
      for (int k = 0; k < P; k++)
        hit_q[k] <= scanning && lane_ok[k] && (lane_sum[k] == '0);
      if (accept) begin
        beats_left_q <= CW'(C - 1);
        pos_q        <= '0;
        for (int j = 0; j <= T; j++) r_q[j] <= bus.sigma_i[j*M +: M];
      end else if (scanning) begin
        beats_left_q <= beats_left_q - CW'(1);
        pos_q        <= pos_q + PBW'(P);
        for (int j = 0; j <= T; j++) r_q[j] <= r_d[j];
      end
    end
  end

  assign bus.sigma_ready_o = (state_q == IDLE);
  assign bus.chien_busy    = busy_q;
  assign bus.chien_done    = done_q;
  assign bus.hit_mask_o    = hit_q;
  assign bus.pos_base_o    = base_q;

`ifdef CHIEN_ODD_SUM_EN
  gf_t            lane_odd [P];
  logic [P*M-1:0] odd_q;

  // Odd-j terms give x*Lambda'(x), the Forney denominator.
  always_comb begin
    for (int k = 0; k < P; k++) begin
      lane_odd[k] = '0;
      for (int j = 1; j <= T; j += 2) lane_odd[k] ^= lane_term[k][j];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      odd_q <= '0;
    end else begin
      for (int k = 0; k < P; k++)
        odd_q[k*M +: M] <= (scanning && lane_ok[k]) ? lane_odd[k] : '0;
    end
  end

  assign bus.lam_odd_o = odd_q;
`endif
endmodule

// File: tb/tb_chien_search_engine.sv
// Scoreboard bench for chien_search_engine: default N=544 instance plus an N=40 instance.
`timescale 1ns/1ps
module tb_chien_search_engine;
  import rs_pkg::*;

  localparam int NB = 544, PB = 32, TB = 15, CB = 17;
  localparam int NS = 40, CS = 2;
  localparam int SW = (TB + 1) * M;

  typedef struct {
    int cyc;
    int base;
    logic [PB-1:0] mask;
    logic done;
`ifdef CHIEN_ODD_SUM_EN
    logic [PB*M-1:0] odd;
`endif
  } beat_t;

  typedef struct {
    int nr; int r0; int r1; int r2;
    bit zero_poly; bit x_only;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  chien_search_engine_if #(.N(NB), .P(PB), .T(TB)) bus ();
  chien_search_engine_if #(.N(NS), .P(PB), .T(TB)) bus_s ();

  chien_search_engine #(.N(NB), .P(PB), .T(TB)) dut   (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  chien_search_engine #(.N(NS), .P(PB), .T(TB)) dut_s (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_s));

  int n_vec = 0, n_err = 0, cyc = 0;
  int alog [0:1022];
  int lg   [0:1023];
  beat_t q_main[$], q_small[$];
  beat_t em, es;
  bit prev_done_m = 0, prev_done_s = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return alog[(lg[a] + lg[b]) % 1023];
  endfunction

  function automatic int gapow(int e);
    return alog[((e % 1023) + 1023) % 1023];
  endfunction

  function automatic vec_t mk(int nr, int a, int b, int c, bit zp, bit xo);
    vec_t v;
    v.nr = nr; v.r0 = a; v.r1 = b; v.r2 = c; v.zero_poly = zp; v.x_only = xo;
    return v;
  endfunction

  // Lambda = product of (1 + alpha^r x); hp marks the root positions.
  task automatic build(input vec_t v, output logic [SW-1:0] sg, output logic [1023:0] hp);
    int cf [16];
    int rr [3];
    rr[0] = v.r0; rr[1] = v.r1; rr[2] = v.r2;
    for (int j = 0; j < 16; j++) cf[j] = 0;
    hp = '0;
    if (v.zero_poly) hp = '1;
    else if (v.x_only) cf[1] = 1;
    else begin
      cf[0] = 1;
      for (int i = 0; i < v.nr; i++) begin
        for (int j = 15; j > 0; j--) cf[j] ^= gmul(gapow(rr[i]), cf[j-1]);
        hp[rr[i]] = 1'b1;
      end
    end
    sg = '0;
    for (int j = 0; j < 16; j++) sg[j*M +: M] = 10'(cf[j]);
  endtask

  function automatic beat_t exp_beat(input logic [1023:0] hp, input logic [SW-1:0] sg,
                                     input int n, input int c, input int x);
    beat_t b;
    b.cyc  = x + 2 + c;
    b.base = c * PB;
    b.done = (c == (n + PB - 1) / PB - 1);
    b.mask = '0;
`ifdef CHIEN_ODD_SUM_EN
    b.odd = '0;
`endif
    for (int k = 0; k < PB; k++) begin
      int i;
      i = c * PB + k;
      if (i < n) begin
        b.mask[k] = hp[i];
`ifdef CHIEN_ODD_SUM_EN
        begin
          int acc;
          acc = 0;
          for (int j = 1; j <= TB; j += 2) acc ^= gmul(int'(sg[j*M +: M]), gapow(-i * j));
          b.odd[k*M +: M] = 10'(acc);
        end
`endif
      end
    end
    return b;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input beat_t e, input int base,
                          input logic [PB-1:0] mask, input logic done);
    n_vec++;
    if (e.cyc != cyc || e.base != base || e.mask !== mask || e.done !== done) begin
      n_err++;
      $display("FAIL %s_beat: cyc %0d base %0d mask %h done %b, expected cyc %0d base %0d mask %h done %b",
               nm, cyc, base, mask, done, e.cyc, e.base, e.mask, e.done);
    end
  endtask

  task automatic start_main(input logic [SW-1:0] sg, input logic [1023:0] hp, output int x);
    int b = 0;
    @(negedge clk_i);
    while (!bus.sigma_ready_o && b < 200) begin @(negedge clk_i); b++; end
    x = cyc;
    if (!bus.sigma_ready_o) begin
      n_vec++; n_err++;
      $display("FAIL main_ready_timeout: ready %b expected 1", bus.sigma_ready_o);
      return;
    end
    bus.sigma_i = sg; bus.sigma_start_i = 1'b1; bus.sigma_valid_i = 1'b1;
    for (int c = 0; c < CB; c++) q_main.push_back(exp_beat(hp, sg, NB, c, x));
    @(negedge clk_i);
    bus.sigma_start_i = 1'b0; bus.sigma_valid_i = 1'b0;
  endtask

  task automatic start_small(input logic [SW-1:0] sg, input logic [1023:0] hp);
    int x;
    @(negedge clk_i);
    x = cyc;
    chk("small_ready_before_start", bus_s.sigma_ready_o, 1);
    bus_s.sigma_i = sg; bus_s.sigma_start_i = 1'b1; bus_s.sigma_valid_i = 1'b1;
    for (int c = 0; c < CS; c++) q_small.push_back(exp_beat(hp, sg, NS, c, x));
    @(negedge clk_i);
    bus_s.sigma_start_i = 1'b0; bus_s.sigma_valid_i = 1'b0;
  endtask

  task automatic wait_queues();
    int b = 0;
    while ((q_main.size() != 0 || q_small.size() != 0) && b < 100) begin @(negedge clk_i); b++; end
    if (q_main.size() != 0 || q_small.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d/%0d beats outstanding, expected 0", q_main.size(), q_small.size());
      q_main.delete(); q_small.delete();
    end
    repeat (2) @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_done_m <= 1'b0;
      prev_done_s <= 1'b0;
    end else begin
      if (bus.chien_busy) begin
        chk("main_ready_in_scan", bus.sigma_ready_o, 0);
        if (q_main.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL main_unexpected_beat: base %0d busy 1 expected busy 0", bus.pos_base_o);
        end else begin
          em = q_main.pop_front();
          chk_beat("main", em, int'(bus.pos_base_o), bus.hit_mask_o, bus.chien_done);
`ifdef CHIEN_ODD_SUM_EN
          n_vec++;
          if (bus.lam_odd_o !== em.odd) begin
            n_err++;
            $display("FAIL main_lam_odd: base %0d got %h expected %h", em.base, bus.lam_odd_o, em.odd);
          end
`endif
        end
      end else begin
        chk("main_idle_outputs", {bus.chien_done, bus.hit_mask_o, bus.pos_base_o}, 0);
`ifdef CHIEN_ODD_SUM_EN
        chk("main_idle_lam_odd_nonzero", longint'(|bus.lam_odd_o), 0);
`endif
      end
      if (prev_done_m) chk("main_ready_after_done", {bus.sigma_ready_o, bus.chien_busy}, 2);
      prev_done_m <= bus.chien_done;

      if (bus_s.chien_busy) begin
        if (q_small.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL small_unexpected_beat: base %0d busy 1 expected busy 0", bus_s.pos_base_o);
        end else begin
          es = q_small.pop_front();
          chk_beat("small", es, int'(bus_s.pos_base_o), bus_s.hit_mask_o, bus_s.chien_done);
        end
      end else begin
        chk("small_idle_outputs", {bus_s.chien_done, bus_s.hit_mask_o, bus_s.pos_base_o}, 0);
      end
      if (prev_done_s) chk("small_ready_after_done", bus_s.sigma_ready_o, 1);
      prev_done_s <= bus_s.chien_done;
    end
  end

  initial begin
    vec_t vecs [7];
    logic [SW-1:0] sg;
    logic [1023:0] hp;
    int x1, x2, b;

    bus.sigma_start_i = 0; bus.sigma_valid_i = 0; bus.sigma_i = '0;
    bus_s.sigma_start_i = 0; bus_s.sigma_valid_i = 0; bus_s.sigma_i = '0;
    rst_i = 1'b1;

    begin
      int xv;
      xv = 1;
      for (int i = 0; i < 1023; i++) begin
        alog[i] = xv; lg[xv] = i;
        xv = xv << 1;
        if ((xv & 1024) != 0) xv ^= 'h409;
      end
    end

    vecs[0] = mk(0, 0, 0, 0, 0, 0);     // Lambda = 1: no roots
    vecs[1] = mk(1, 5, 0, 0, 0, 0);     // single root at position 5
    vecs[2] = mk(2, 40, 543, 0, 0, 0);  // beat 1 bit 8, beat 16 bit 31
    vecs[3] = mk(3, 0, 100, 300, 0, 0);
    vecs[4] = mk(0, 0, 0, 0, 1, 0);     // Lambda = 0: every position hits
    vecs[5] = mk(0, 0, 0, 0, 0, 1);     // lambda_0 = 0, Lambda = x
    vecs[6] = mk(2, 31, 32, 0, 0, 0);   // roots straddling a beat boundary

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_ready", bus.sigma_ready_o, 1);
    chk("reset_busy", bus.chien_busy, 0);
    chk("reset_done", bus.chien_done, 0);
    chk("reset_mask", bus.hit_mask_o, 0);
    chk("reset_pos_base", bus.pos_base_o, 0);
    chk("reset_small_ready", bus_s.sigma_ready_o, 1);
    rst_i = 1'b0;

    for (int v = 0; v < 7; v++) begin
      build(vecs[v], sg, hp);
      start_main(sg, hp, x1);
      wait_queues();
    end

    // Back-to-back with an ignored start pulse mid-scan.
    build(vecs[1], sg, hp);
    start_main(sg, hp, x1);
    b = 0;
    while (cyc < x1 + 5 && b < 50) begin @(negedge clk_i); b++; end
    bus.sigma_i = '0; bus.sigma_start_i = 1'b1; bus.sigma_valid_i = 1'b1;
    @(negedge clk_i);
    bus.sigma_start_i = 1'b0; bus.sigma_valid_i = 1'b0;
    build(vecs[2], sg, hp);
    start_main(sg, hp, x2);
    chk("b2b_accept_gap", x2 - x1, CB + 2);
    wait_queues();

    // Qualifier halves alone must not start a scan.
    bus.sigma_i = '0; bus.sigma_valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    bus.sigma_valid_i = 1'b0; bus.sigma_start_i = 1'b1;
    repeat (3) @(negedge clk_i);
    bus.sigma_start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("half_qualifier_ready", bus.sigma_ready_o, 1);

    // Reset during beat 7.
    build(vecs[3], sg, hp);
    start_main(sg, hp, x1);
    b = 0;
    while (cyc != x1 + 9 && b < 50) begin @(negedge clk_i); b++; end
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    q_main.delete();
    chk("abort_busy", bus.chien_busy, 0);
    chk("abort_done", bus.chien_done, 0);
    chk("abort_mask", bus.hit_mask_o, 0);
    chk("abort_pos_base", bus.pos_base_o, 0);
    chk("abort_ready", bus.sigma_ready_o, 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (25) @(negedge clk_i);

    // Short code: tail lanes beyond N=40 must be masked.
    build(mk(2, 3, 50, 0, 0, 0), sg, hp);
    start_small(sg, hp);
    wait_queues();
    build(vecs[4], sg, hp);
    start_small(sg, hp);
    wait_queues();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/chien_search_engine.md
Name: chien_search_engine

Overview:
- Parallel Chien search for the RS(544,514) decoder over GF(2^10).
- Takes the error-locator polynomial Λ(x) from the key-equation solver and evaluates it at α^(-i) for positions i = 0..N-1, P positions per cycle.
- Drives the per-cycle root hit mask plus busy/done framing consumed by the root counter and the Forney stage.
- Guarantees that tail lanes beyond N are zero.

Parameters:
- M, 10: symbol width in bits. Field is GF(2^M) with primitive polynomial x^10+x^3+1.
- N, 544: number of codeword positions to scan.
- P, 32: lanes (positions evaluated) per cycle.
- T, 15: maximum Λ degree; T+1 coefficients.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- sigma_start_i  in  1  start qualifier for a new polynomial.
- sigma_valid_i  in  1  coefficients valid. Accept happens when sigma_start_i && sigma_valid_i && sigma_ready_o.
- sigma_i  in  (T+1)*M  Λ coefficients; λ_j is at bits [j*M +: M] (λ_0 in the LSBs).
- sigma_ready_o  out  1  engine idle and able to accept.
- chien_busy  out  1  high for every output beat of a scan.
- chien_done  out  1  high on the last beat only, coincident with chien_busy.
- hit_mask_o  out  P  bit k set ⇒ Λ(α^(-(base+k))) == 0.
- pos_base_o  out  $clog2(N)  position of lane 0 in the current beat (c*P).

Behaviour:
- Beat count: C = ceil(N/P); default C = 17.
- Reset values: sigma_ready_o = 1; chien_busy, chien_done, hit_mask_o, pos_base_o = 0. Coefficient registers and counter cleared. FSM returns to IDLE.
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE → SCAN on accept. Load r_j <= λ_j for j = 0..T; beat counter c <= 0; sigma_ready_o <= 0.
  - SCAN evaluates one beat per cycle:
    - Lane k term: S_k = XOR over j of r_j·α^(-j·k).
    - Raw hit_k = (S_k == 0).
    - Lane mask: hit_k is forced to 0 when c*P+k >= N.
    - Coefficient update: r_j <= r_j·α^(-j·P).
    - On c = C-1, go to DRAIN.
  - DRAIN lasts one cycle (output register flush), then returns to IDLE with sigma_ready_o <= 1.
- Output register stage:
  - hit_mask_o, pos_base_o, chien_busy and chien_done are registered.
  - Beat c appears one cycle after it is evaluated.
  - First beat is on cycle accept+2; chien_busy is high for exactly C consecutive cycles.
  - chien_done is high on the final beat only.
- sigma_ready_o returns to 1 on the cycle after chien_done. Earliest next accept is that cycle, giving one idle cycle between scans.
- Start while not ready: ignored, with no effect on the scan in progress.
- sigma_valid_i without sigma_start_i: ignored.
- Arithmetic:
  - GF adds are XOR.
  - Constant multipliers α^e use e reduced mod (2^M - 1), computed at elaboration.
  - All lane sums are M bits.
- Degenerate inputs:
  - Λ = 0 (all coefficients zero): every in-range lane hits. No special handling; the downstream consumer detects the failure.
  - λ_0 = 0: scanned as given.
- Reset asserted mid-scan: outputs go to their reset values on the next edge; no done pulse is produced.

Optional Feature:
- Macro: CHIEN_ODD_SUM_EN.
- Defined: adds output lam_odd_o (P*M bits).
  - Lane k carries XOR over odd j of r_j·α^(-j·k), i.e. x·Λ'(x) at α^(-(base+k)), for the Forney denominator.
  - Registered and aligned with hit_mask_o.
  - Zero outside busy beats and in masked tail lanes.
- Undefined: port and logic absent; all other behaviour is identical.

Decomposition:
- Shared package rs_pkg holds:
  - M, N, T, P defaults and the primitive polynomial constant.
  - typedef gf_t (logic [M-1:0]).
  - Elaboration-time function gf_alpha_pow(e) returning α^e as gf_t, used to derive constant-multiplier matrices.
- One sub-module gf_const_mul #(E): M-bit input times fixed α^E, pure XOR network, combinational. It is instantiated for the lane terms and the coefficient update.

Test Plan:
- Λ = 1 (λ_0 = 1, rest 0), accept → chien_busy high 17 cycles starting accept+2; chien_done on the 17th; hit_mask_o = 0 every beat; pos_base_o steps 0, 32, …, 512.
- Λ = 1 + α^5·x → exactly one hit: beat 0 (pos_base_o = 0), bit 5. All other beats zero.
- Λ = (1 + α^40·x)(1 + α^543·x) → hits at beat 1 bit 8 and beat 16 bit 31 only. Root counter downstream reports 2 with root_cnt_valid_o on the done beat.
- N = 40, P = 32, Λ = (1 + α^3·x)(1 + α^50·x) → C = 2; beat 0 bit 3 set; beat 1 mask = 0 (position 50 masked, lanes 8..31 zero); done on beat 1.
- Back-to-back and abort:
  - Second start/valid pulse during a scan → ignored.
  - Next accept taken on the cycle after chien_done → its first beat follows 2 cycles later.
  - rst_i asserted at beat 7 → busy, done, mask at 0 next cycle; sigma_ready_o = 1.
- CHIEN_ODD_SUM_EN, Λ = 1 + α^5·x → lam_odd_o lane k equals α^5·α^(-k); at the hit lane (k = 5) it equals 1.
